id_stage: RTL and testbench

Decode stage of the RISCV-Lite pipeline. Takes a fetched RV32I instruction from IF, reads the register file, and builds the immediate. It selects the ALU operands, generates the `alu_ops_t` control word, and presents everything to EX through a registered ID/EX boundary with a valid/ready handshake. It is the producing end of the ALU operand/control interface, and it owns load-use hazard stalling and branch-flush handling.

---
 rtl/my_pkg.sv | 9 +
 rtl/id_stage.sv | 196 +++++++++++++++++++
 tb/tb_id_stage.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/my_pkg.sv
// rtl/my_pkg.sv - shared RISCV-Lite pipeline types
package my_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
    } alu_ops_t;

endpackage

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage with registered ID/EX boundary and load-use stall
module id_stage
    import my_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        id_ready,
    output logic [4:0]  rf_rs1_addr,
    output logic [4:0]  rf_rs2_addr,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [31:0] ex_op1,
    output logic [31:0] ex_op2,
    output alu_ops_t    ex_alu_ctrl,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_is_branch,
    output logic        ex_is_jal,
    output logic        ex_is_jalr,
    output logic        ex_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        f7_zero, f7_alt;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode      = if_instr[6:0];
    assign rd          = if_instr[11:7];
    assign funct3      = if_instr[14:12];
    assign funct7      = if_instr[31:25];
    assign rf_rs1_addr = if_instr[19:15];
    assign rf_rs2_addr = if_instr[24:20];
    assign f7_zero     = (funct7 == 7'h00);
    assign f7_alt      = (funct7 == 7'h20);

    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

    logic [31:0] op1_d, op2_d, imm_d;
    alu_ops_t    alu_d;
    logic        rw_d, mr_d, mw_d, br_d, jal_d, jalr_d, ill_d, uses_rs1, uses_rs2;

    always_comb begin
        op1_d = '0; op2_d = '0; imm_d = '0; alu_d = ALU_ADD;
        rw_d = 1'b0; mr_d = 1'b0; mw_d = 1'b0; br_d = 1'b0;
        jal_d = 1'b0; jalr_d = 1'b0; ill_d = 1'b0;
        uses_rs1 = 1'b0; uses_rs2 = 1'b0;
        case (opcode)
            OPC_OP: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; rw_d = 1'b1;
                op1_d = rf_rs1_data; op2_d = rf_rs2_data;
                case (funct3)
                    3'b000: begin alu_d = f7_alt ? ALU_SUB : ALU_ADD; ill_d = ~(f7_zero | f7_alt); end
                    3'b001: begin alu_d = ALU_SLL;  ill_d = ~f7_zero; op2_d = {27'b0, rf_rs2_data[4:0]}; end
                    3'b010: begin alu_d = ALU_SLT;  ill_d = ~f7_zero; end
                    3'b011: begin alu_d = ALU_SLTU; ill_d = ~f7_zero; end
                    3'b100: begin alu_d = ALU_XOR;  ill_d = ~f7_zero; end
                    3'b101: begin
                        alu_d = f7_alt ? ALU_SRA : ALU_SRL; ill_d = ~(f7_zero | f7_alt);
                        op2_d = {27'b0, rf_rs2_data[4:0]};
                    end
                    3'b110: begin alu_d = ALU_OR;   ill_d = ~f7_zero; end
                    default: begin alu_d = ALU_AND; ill_d = ~f7_zero; end
                endcase
            end
            OPC_OPIMM: begin
                uses_rs1 = 1'b1; rw_d = 1'b1;
                op1_d = rf_rs1_data; op2_d = imm_i; imm_d = imm_i;
                case (funct3)
                    3'b000: alu_d = ALU_ADD;
                    3'b001: begin alu_d = ALU_SLL; ill_d = ~f7_zero; op2_d = {27'b0, if_instr[24:20]}; end
                    3'b010: alu_d = ALU_SLT;
                    3'b011: alu_d = ALU_SLTU;
                    3'b100: alu_d = ALU_XOR;
                    3'b101: begin
                        alu_d = f7_alt ? ALU_SRA : ALU_SRL; ill_d = ~(f7_zero | f7_alt);
                        op2_d = {27'b0, if_instr[24:20]};
                    end
                    3'b110: alu_d = ALU_OR;
                    default: alu_d = ALU_AND;
                endcase
            end
            OPC_LOAD: begin
                uses_rs1 = 1'b1; rw_d = 1'b1; mr_d = 1'b1;
                op1_d = rf_rs1_data; op2_d = imm_i; imm_d = imm_i;
                ill_d = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; mw_d = 1'b1;
                op1_d = rf_rs1_data; op2_d = imm_s; imm_d = imm_s;
                ill_d = funct3[2] | (funct3 == 3'b011);
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; br_d = 1'b1;
                op1_d = rf_rs1_data; op2_d = rf_rs2_data; imm_d = imm_b;
                case (funct3)
                    3'b000: alu_d = ALU_BEQ;
                    3'b001: alu_d = ALU_BNE;
                    3'b100: alu_d = ALU_BLT;
                    3'b101: alu_d = ALU_BGE;
                    3'b110: alu_d = ALU_BLTU;
                    3'b111: alu_d = ALU_BGEU;
                    default: ill_d = 1'b1;
                endcase
            end
            OPC_LUI:   begin rw_d = 1'b1; op2_d = imm_u; imm_d = imm_u; end
            OPC_AUIPC: begin rw_d = 1'b1; op1_d = if_pc; op2_d = imm_u; imm_d = imm_u; end
            OPC_JAL:   begin rw_d = 1'b1; jal_d = 1'b1; op1_d = if_pc; op2_d = 32'd4; imm_d = imm_j; end
            OPC_JALR: begin
                uses_rs1 = 1'b1; rw_d = 1'b1; jalr_d = 1'b1;
                op1_d = if_pc; op2_d = 32'd4; imm_d = imm_i;
                ill_d = (funct3 != 3'b000);
            end
            default: ill_d = 1'b1;
        endcase
        // Illegal words travel down as a harmless ADD 0,0 so EX only needs to look at ex_illegal.
        if (ill_d) begin
            op1_d = '0; op2_d = '0; imm_d = '0; alu_d = ALU_ADD;
            rw_d = 1'b0; mr_d = 1'b0; mw_d = 1'b0; br_d = 1'b0; jal_d = 1'b0; jalr_d = 1'b0;
        end
        if (rd == 5'd0) rw_d = 1'b0;
    end

    logic        valid_q, rw_q, mr_q, mw_q, br_q, jal_q, jalr_q, ill_q;
    logic [31:0] op1_q, op2_q, imm_q, pc_q, sd_q;
    logic [4:0]  rd_q;
    alu_ops_t    alu_q;
    logic        load, hz, take;

    assign load     = ~valid_q | ex_ready;
    assign hz       = valid_q & mr_q & (rd_q != 5'd0) &
                      (((rd_q == rf_rs1_addr) & uses_rs1) | ((rd_q == rf_rs2_addr) & uses_rs2));
    assign id_ready = rst_n & load & (~hz | flush);
    assign take     = if_valid & ~flush & ~hz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0; op1_q <= '0; op2_q <= '0; imm_q <= '0; pc_q <= '0; sd_q <= '0;
            rd_q <= '0; alu_q <= ALU_ADD; rw_q <= 1'b0; mr_q <= 1'b0; mw_q <= 1'b0;
            br_q <= 1'b0; jal_q <= 1'b0; jalr_q <= 1'b0; ill_q <= 1'b0;
        end else if (load) begin
            if (take) begin
                valid_q <= 1'b1; op1_q <= op1_d; op2_q <= op2_d; imm_q <= imm_d; pc_q <= if_pc;
                sd_q <= rf_rs2_data; rd_q <= rd; alu_q <= alu_d; rw_q <= rw_d; mr_q <= mr_d;
                mw_q <= mw_d; br_q <= br_d; jal_q <= jal_d; jalr_q <= jalr_d; ill_q <= ill_d;
            end else begin
                valid_q <= 1'b0; op1_q <= '0; op2_q <= '0; imm_q <= '0; pc_q <= '0; sd_q <= '0;
                rd_q <= '0; alu_q <= ALU_ADD; rw_q <= 1'b0; mr_q <= 1'b0; mw_q <= 1'b0;
                br_q <= 1'b0; jal_q <= 1'b0; jalr_q <= 1'b0; ill_q <= 1'b0;
            end
        end
    end

    assign ex_valid      = valid_q;
    assign ex_op1        = op1_q;
    assign ex_op2        = op2_q;
    assign ex_alu_ctrl   = alu_q;
    assign ex_imm        = imm_q;
    assign ex_pc         = pc_q;
    assign ex_store_data = sd_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = rw_q;
    assign ex_mem_read   = mr_q;
    assign ex_mem_write  = mw_q;
    assign ex_is_branch  = br_q;
    assign ex_is_jal     = jal_q;
    assign ex_is_jalr    = jalr_q;
    assign ex_illegal    = ill_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;
    import my_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, if_valid, flush, ex_ready;
    logic [31:0] if_instr, if_pc, rf_rs1_data, rf_rs2_data;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic        id_ready, ex_valid;
    logic [31:0] ex_op1, ex_op2, ex_imm, ex_pc, ex_store_data;
    alu_ops_t    ex_alu_ctrl;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_is_jal, ex_is_jalr, ex_illegal;
    logic [31:0] regs [32];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always_comb rf_rs1_data = regs[rf_rs1_addr];
    always_comb rf_rs2_data = regs[rf_rs2_addr];

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_illegal(ex_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1; if_instr = instr; if_pc = pc;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h0;
        flush = 1'b0; ex_ready = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        tick(); tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", ex_valid); end
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL reset_id_ready: got %b exp 0", id_ready); end
        checks++; if (ex_alu_ctrl !== ALU_ADD || ex_op1 !== 32'h0 || ex_reg_write !== 1'b0)
            begin errors++; $display("FAIL reset_outputs: alu %0d op1 %h rw %b exp 0/0/0", ex_alu_ctrl, ex_op1, ex_reg_write); end
        rst_n = 1'b1; if_valid = 1'b0;
        tick();
    endtask

    task automatic test_addi();
        present(32'h00500093, 32'h100);
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL addi_id_ready: got %b exp 1", id_ready); end
        tick(); if_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1 || ex_op1 !== 32'h0 || ex_op2 !== 32'h5)
            begin errors++; $display("FAIL addi_ops: valid %b op1 %h op2 %h exp 1/0/5", ex_valid, ex_op1, ex_op2); end
        checks++; if (ex_alu_ctrl !== ALU_ADD || ex_rd !== 5'd1 || ex_reg_write !== 1'b1 || ex_pc !== 32'h100)
            begin errors++; $display("FAIL addi_ctrl: alu %0d rd %0d rw %b pc %h exp 0/1/1/100", ex_alu_ctrl, ex_rd, ex_reg_write, ex_pc); end
    endtask

    task automatic test_srai();
        regs[1] = 32'hF000_0000;
        present(32'h4030D113, 32'h104);
        tick(); if_valid = 1'b0;
        checks++; if (ex_alu_ctrl !== ALU_SRA || ex_op1 !== 32'hF000_0000 || ex_op2 !== 32'h3 || ex_rd !== 5'd2)
            begin errors++; $display("FAIL srai: alu %0d op1 %h op2 %h rd %0d exp 7/f0000000/3/2", ex_alu_ctrl, ex_op1, ex_op2, ex_rd); end
    endtask

    task automatic test_load_use();
        regs[3] = 32'h11;
        present(32'h0000A183, 32'h108);
        tick();
        checks++; if (ex_mem_read !== 1'b1 || ex_op1 !== 32'hF000_0000 || ex_op2 !== 32'h0 || ex_rd !== 5'd3)
            begin errors++; $display("FAIL lw_decode: mr %b op1 %h op2 %h rd %0d exp 1/f0000000/0/3", ex_mem_read, ex_op1, ex_op2, ex_rd); end
        present(32'h00118233, 32'h10C);
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL lu_stall_ready: got %b exp 0", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0) begin errors++; $display("FAIL lu_bubble: valid %b mr %b exp 0/0", ex_valid, ex_mem_read); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_accept_ready: got %b exp 1", id_ready); end
        tick(); if_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd4 || ex_alu_ctrl !== ALU_ADD || ex_op1 !== 32'h11 || ex_op2 !== 32'hF000_0000)
            begin errors++; $display("FAIL lu_add: valid %b rd %0d alu %0d op1 %h op2 %h exp 1/4/0/11/f0000000", ex_valid, ex_rd, ex_alu_ctrl, ex_op1, ex_op2); end
    endtask

    task automatic test_flush();
        regs[2] = 32'h22;
        present(32'h00208463, 32'h110);
        tick();
        checks++; if (ex_is_branch !== 1'b1 || ex_alu_ctrl !== ALU_BEQ || ex_imm !== 32'h8 || ex_reg_write !== 1'b0 || ex_op2 !== 32'h22)
            begin errors++; $display("FAIL beq_decode: br %b alu %0d imm %h rw %b op2 %h exp 1/10/8/0/22", ex_is_branch, ex_alu_ctrl, ex_imm, ex_reg_write, ex_op2); end
        flush = 1'b1;
        present(32'h00500093, 32'h114);
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", id_ready); end
        tick(); flush = 1'b0; if_valid = 1'b0;
        checks++; if (ex_valid !== 1'b0 || ex_is_branch !== 1'b0 || ex_reg_write !== 1'b0)
            begin errors++; $display("FAIL flush_bubble: valid %b br %b rw %b exp 0/0/0", ex_valid, ex_is_branch, ex_reg_write); end
    endtask

    task automatic test_backpressure();
        present(32'h00500093, 32'h200);
        tick();
        ex_ready = 1'b0;
        present(32'h4030D113, 32'h204);
        for (int i = 0; i < 3; i++) begin
            checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d: got %b exp 0", i, id_ready); end
            tick();
            checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h200 || ex_op2 !== 32'h5 || ex_alu_ctrl !== ALU_ADD)
                begin errors++; $display("FAIL bp_hold_%0d: valid %b pc %h op2 %h alu %0d exp 1/200/5/0", i, ex_valid, ex_pc, ex_op2, ex_alu_ctrl); end
        end
        ex_ready = 1'b1; #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b exp 1", id_ready); end
        tick(); if_valid = 1'b0;
        checks++; if (ex_pc !== 32'h204 || ex_alu_ctrl !== ALU_SRA)
            begin errors++; $display("FAIL bp_next: pc %h alu %0d exp 204/7", ex_pc, ex_alu_ctrl); end
    endtask

    task automatic test_upper_jump();
        present(32'h123452B7, 32'h300);
        tick();
        checks++; if (ex_op1 !== 32'h0 || ex_op2 !== 32'h1234_5000 || ex_rd !== 5'd5)
            begin errors++; $display("FAIL lui: op1 %h op2 %h rd %0d exp 0/12345000/5", ex_op1, ex_op2, ex_rd); end
        present(32'h00001317, 32'h304);
        tick();
        checks++; if (ex_op1 !== 32'h304 || ex_op2 !== 32'h1000)
            begin errors++; $display("FAIL auipc: op1 %h op2 %h exp 304/1000", ex_op1, ex_op2); end
        present(32'h010000EF, 32'h308);
        tick(); if_valid = 1'b0;
        checks++; if (ex_is_jal !== 1'b1 || ex_op1 !== 32'h308 || ex_op2 !== 32'h4 || ex_imm !== 32'h10 || ex_reg_write !== 1'b1)
            begin errors++; $display("FAIL jal: jal %b op1 %h op2 %h imm %h rw %b exp 1/308/4/10/1", ex_is_jal, ex_op1, ex_op2, ex_imm, ex_reg_write); end
    endtask

    task automatic test_illegal();
        present(32'h0000007F, 32'h400);
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_illegal !== 1'b1 || ex_reg_write !== 1'b0 || ex_op1 !== 32'h0 || ex_op2 !== 32'h0 || ex_alu_ctrl !== ALU_ADD)
            begin errors++; $display("FAIL illegal_opc: v %b ill %b rw %b op1 %h op2 %h alu %0d exp 1/1/0/0/0/0", ex_valid, ex_illegal, ex_reg_write, ex_op1, ex_op2, ex_alu_ctrl); end
        present(32'h02118233, 32'h404);
        tick();
        checks++; if (ex_illegal !== 1'b1 || ex_reg_write !== 1'b0 || ex_op1 !== 32'h0)
            begin errors++; $display("FAIL illegal_f7: ill %b rw %b op1 %h exp 1/0/0", ex_illegal, ex_reg_write, ex_op1); end
        present(32'h00100013, 32'h408);
        tick(); if_valid = 1'b0;
        checks++; if (ex_illegal !== 1'b0 || ex_reg_write !== 1'b0 || ex_op2 !== 32'h1)
            begin errors++; $display("FAIL rd_x0: ill %b rw %b op2 %h exp 0/0/1", ex_illegal, ex_reg_write, ex_op2); end
    endtask

    task automatic test_reset_mid_stall();
        present(32'h0000A183, 32'h500);
        tick();
        ex_ready = 1'b0;
        present(32'h00118233, 32'h504);
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL rst_stall_ready: got %b exp 0", id_ready); end
        rst_n = 1'b0; #1;
        checks++; if (ex_valid !== 1'b0 || id_ready !== 1'b0 || ex_mem_read !== 1'b0)
            begin errors++; $display("FAIL rst_async: valid %b ready %b mr %b exp 0/0/0", ex_valid, id_ready, ex_mem_read); end
        tick();
        rst_n = 1'b1; ex_ready = 1'b1;
        present(32'h00500093, 32'h600);
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL rst_first_ready: got %b exp 1", id_ready); end
        tick(); if_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd1 || ex_pc !== 32'h600)
            begin errors++; $display("FAIL rst_first_instr: valid %b rd %0d pc %h exp 1/1/600", ex_valid, ex_rd, ex_pc); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_srai();
        test_load_use();
        test_flush();
        test_backpressure();
        test_upper_jump();
        test_illegal();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
